// File: rtl/spi_pkg.sv
// Shared types for the multi-chip-select SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE_RESET = '{cpol: 1'b0, cpha: 1'b0};

endpackage

// File: rtl/spi_clk_divider.sv
// SCLK half-period timer: ticks every CLK_DIV cycles while enabled.
// lead tells whether the upcoming tick is a leading (1) or trailing (0) SCLK edge.
module spi_clk_divider #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic edge_tick_c,
    output logic lead
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign edge_tick_c = en && (cnt == CNT_W'(CLK_DIV - 1));

    // Half-period counter and edge-type flag; load restarts a frame with a leading edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            lead <= 1'b1;
        end else if (load) begin
            cnt  <= '0;
            lead <= 1'b1;
        end else if (en) begin
            if (edge_tick_c) begin
                cnt  <= '0;
                lead <= ~lead;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master: MSB-first frames, NUM_CS chip selects, per-transaction CPOL/CPHA.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_n,
    input  logic                  miso
);

    localparam int unsigned BCNT_W = $clog2(DATA_WIDTH + 1);

    spi_state_t            state, state_d;
    spi_mode_t             mode_q, mode_d;
    logic [DATA_WIDTH-1:0] tx_sh, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh, rxs_d;
    logic [DATA_WIDTH-1:0] rxd_d;
    logic [BCNT_W-1:0]     bit_cnt, bit_d;
    logic                  sclk_d, ready_d, done_d, err_d;
    logic [NUM_CS-1:0]     cs_n_d;
    logic                  load_c, cs_ok_c, tick_c, lead;
    logic                  miso_meta, miso_s;

    // MOSI is the shift register MSB, so it is a flop output
    assign mosi = tx_sh[DATA_WIDTH-1];

    spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_c),
        .en          (state != IDLE),
        .edge_tick_c (tick_c),
        .lead        (lead)
    );

    // Two-flop synchronizer for the asynchronous MISO pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_s    <= miso_meta;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        tx_d    = tx_sh;
        rxs_d   = rx_sh;
        rxd_d   = rx_data;
        bit_d   = bit_cnt;
        sclk_d  = sclk;
        cs_n_d  = cs_n;
        ready_d = ready;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_c  = 1'b0;
        cs_ok_c = 32'(cs_sel) < 32'(NUM_CS);

        unique case (state)
            IDLE: begin
                sclk_d = mode_q.cpol;
                if (start && ready) begin
                    if (cs_ok_c) begin
                        mode_d.cpol = cpol;
                        mode_d.cpha = cpha;
                        tx_d        = tx_data;
                        sclk_d      = cpol;
                        cs_n_d      = ~(NUM_CS'(1) << cs_sel);
                        bit_d       = '0;
                        ready_d     = 1'b0;
                        load_c      = 1'b1;
                        state_d     = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // First tick is the leading edge of bit 0; CPHA=1 already has the MSB on MOSI
            SETUP: begin
                if (tick_c) begin
                    sclk_d  = ~sclk;
                    state_d = SHIFT;
                    if (!mode_q.cpha) begin
                        rxs_d = {rx_sh[DATA_WIDTH-2:0], miso_s};
                    end
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    if (lead) begin
                        if (bit_cnt == BCNT_W'(DATA_WIDTH)) begin
                            state_d = HOLD;
                        end else begin
                            sclk_d = ~sclk;
                            if (!mode_q.cpha) begin
                                rxs_d = {rx_sh[DATA_WIDTH-2:0], miso_s};
                            end else begin
                                tx_d = {tx_sh[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end else begin
                        sclk_d = ~sclk;
                        bit_d  = bit_cnt + BCNT_W'(1);
                        if (mode_q.cpha) begin
                            rxs_d = {rx_sh[DATA_WIDTH-2:0], miso_s};
                        end else if (bit_cnt != BCNT_W'(DATA_WIDTH - 1)) begin
                            tx_d = {tx_sh[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                sclk_d = mode_q.cpol;
                if (tick_c) begin
                    cs_n_d  = '1;
                    rxd_d   = rx_sh;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset releases chip selects immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_RESET;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            cs_n    <= '1;
            ready   <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            mode_q  <= mode_d;
            tx_sh   <= tx_d;
            rx_sh   <= rxs_d;
            rx_data <= rxd_d;
            bit_cnt <= bit_d;
            sclk    <= sclk_d;
            cs_n    <= cs_n_d;
            ready   <= ready_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule
